// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter of fetch and load/store requests onto one word-addressed memory port
module mem_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_req_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic [DATA_W-1:0] if_resp_data,
  output logic              if_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [31:0]       d_req_addr,
  input  logic              d_req_we,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  input  logic              d_resp_ready,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;
  state_t state, state_nxt;
  logic last_d, gnt_if, gnt_d, gnt, err, resp_err;
  logic [31:0] addr;
  logic [DATA_W-1:0] resp_data;
  always_comb begin
    gnt_d = rst_n && state == IDLE && d_req_valid && (!if_req_valid || !last_d);
    gnt_if = rst_n && state == IDLE && if_req_valid && (!d_req_valid || last_d);
    gnt = gnt_d || gnt_if;
    addr = gnt_d ? d_req_addr : if_req_addr;
    err = addr[1:0] != 2'b00 || addr[31:ADDR_W+2] != '0;
    state_nxt = state == IDLE ? (gnt_d ? RESP_D : gnt_if ? RESP_IF : IDLE)
              : state == RESP_IF ? (if_resp_ready ? IDLE : RESP_IF)
              : (d_resp_ready ? IDLE : RESP_D);
  end
  assign if_req_ready = gnt_if;
  assign d_req_ready = gnt_d;
  assign mem_addr = gnt ? addr[ADDR_W+1:2] : '0;
  assign mem_we = gnt_d && d_req_we && !err;
  assign mem_wdata = d_req_wdata;
  assign if_resp_valid = state == RESP_IF;
  assign d_resp_valid = state == RESP_D;
  assign if_resp_data = if_resp_valid ? resp_data : '0;
  assign d_resp_data = d_resp_valid ? resp_data : '0;
  assign if_resp_err = if_resp_valid && resp_err;
  assign d_resp_err = d_resp_valid && resp_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last_d <= 1'b0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt) begin
        last_d <= gnt_d;
        resp_data <= (err || (gnt_d && d_req_we)) ? '0 : mem_rdata;
        resp_err <= err;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a transaction-level model of arbitration and memory
module tb_mem_port_arbiter;
  logic clk = 0, rst_n;
  logic if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err;
  logic [31:0] if_req_addr, if_resp_data;
  logic d_req_valid, d_req_ready, d_req_we, d_resp_valid, d_resp_ready, d_resp_err;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
  logic [6:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic mem_we;
  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  logic [32:0] q_if[$], q_d[$];
  bit busy, busy_d, m_last_d, was_rst, ref_ready;
  int checks = 0, errors = 0, cyc = 0;
  int g_port[$], g_cyc[$];

  mem_port_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr), .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (cyc == 0) for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] gen_addr();
    int r = $urandom_range(0, 9);
    logic [31:0] a = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
    if (r == 7) a[1:0] = 2'($urandom_range(1, 3));
    else if (r == 8) a = 32'($urandom_range(128, 1023)) << 2;
    else if (r == 9) a = $urandom;
    return a;
  endfunction

  // Reference model: one transaction at a time, round-robin on ties, memory as a plain array.
  always @(negedge clk) begin
    logic eg_if, eg_d, er, we;
    logic [31:0] a;
    logic [32:0] e;
    int w;
    if (!ref_ready) begin
      for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
      ref_ready = 1;
    end
    if (!rst_n) begin
      chk("rst_ready", {if_req_ready, d_req_ready, mem_we}, 0);
      q_if.delete();
      q_d.delete();
      busy = 0;
      m_last_d = 0;
      was_rst = 1;
    end else begin
      if (was_rst) begin
        chk("rst_resp", {if_resp_valid, d_resp_valid, if_resp_err, d_resp_err}, 0);
        chk("rst_data", {if_resp_data, d_resp_data}, 0);
        was_rst = 0;
      end
      if (busy) begin
        chk("busy_ready", {if_req_ready, d_req_ready, mem_we}, 0);
        chk("resp_port", {if_resp_valid, d_resp_valid}, {!busy_d, busy_d});
        e = busy_d ? q_d[0] : q_if[0];
        chk(busy_d ? "d_resp" : "if_resp", busy_d ? {d_resp_err, d_resp_data} : {if_resp_err, if_resp_data}, e);
        if (busy_d ? d_resp_ready : if_resp_ready) begin
          if (busy_d) void'(q_d.pop_front());
          else void'(q_if.pop_front());
          busy = 0;
        end
      end else begin
        chk("idle_resp", {if_resp_valid, d_resp_valid}, 0);
        eg_d = d_req_valid && (!if_req_valid || !m_last_d);
        eg_if = if_req_valid && (!d_req_valid || m_last_d);
        chk("grant", {if_req_ready, d_req_ready}, {eg_if, eg_d});
        a = eg_d ? d_req_addr : if_req_addr;
        er = (a % 4 != 0) || (a >= 32'd512);
        w = int'((a / 4) % 128);
        if (eg_if || eg_d) begin
          we = eg_d && d_req_we && !er;
          chk("mem_addr", mem_addr, w);
          chk("mem_we", mem_we, we);
          if (we) chk("mem_wdata", mem_wdata, d_req_wdata);
          e = {er, (er || (eg_d && d_req_we)) ? 32'h0 : ref_mem[w]};
          if (we) ref_mem[w] = d_req_wdata;
          if (eg_d) q_d.push_back(e);
          else q_if.push_back(e);
          busy = 1;
          busy_d = eg_d;
          m_last_d = eg_d;
        end else chk("mem_we_idle", mem_we, 0);
      end
    end
  end

  task automatic req(input bit d, input logic [31:0] a, input bit we, input logic [31:0] wd);
    bit acc = 0;
    if (d) begin
      d_req_valid = 1; d_req_addr = a; d_req_we = we; d_req_wdata = wd;
    end else begin
      if_req_valid = 1; if_req_addr = a;
    end
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = d ? d_req_valid && d_req_ready : if_req_valid && if_req_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    if (d) begin
      d_req_valid = 0; d_req_addr = $urandom; d_req_we = 1; d_req_wdata = $urandom;
    end else begin
      if_req_valid = 0; if_req_addr = $urandom;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ai, ad;
    rst_n = 0; if_req_valid = 1; if_req_addr = 0; if_resp_ready = 1;
    d_req_valid = 1; d_req_addr = 32'h4; d_req_we = 0; d_req_wdata = 0; d_resp_ready = 1;
    repeat (3) @(posedge clk);
    #1; if_req_valid = 0; d_req_valid = 0; rst_n = 1;
    @(negedge clk);
    chk("reset_idle", {if_resp_valid, d_resp_valid, if_req_ready, d_req_ready}, 0);
    @(posedge clk); #1;
    req(1, 32'h10, 1, 32'hDEADBEEF);
    @(negedge clk);
    chk("store_resp", {d_resp_valid, d_resp_err, d_resp_data}, {2'b10, 32'h0});
    req(1, 32'h10, 0, 0);
    @(negedge clk);
    chk("load_data", d_resp_data, 32'hDEADBEEF);
    if_resp_ready = 0;
    req(0, 32'h10, 0, 0);
    d_req_valid = 1; d_req_addr = 32'h14; d_req_we = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {if_resp_valid, if_resp_data}, {1'b1, 32'hDEADBEEF});
      chk("stall_ready", {if_req_ready, d_req_ready}, 0);
      @(posedge clk); #1;
    end
    if_resp_ready = 1;
    req(1, 32'h14, 0, 0);
    req(1, 32'h13, 1, 32'h12345678);
    @(negedge clk);
    chk("misalign_resp", {d_resp_err, d_resp_data}, {1'b1, 32'h0});
    req(1, 32'h10, 0, 0);
    @(negedge clk);
    chk("misalign_kept", d_resp_data, 32'hDEADBEEF);
    req(0, 32'h200, 0, 0);
    @(negedge clk);
    chk("oob_fetch", {if_resp_valid, if_resp_err, if_resp_data}, {2'b11, 32'h0});
    d_resp_ready = 0;
    req(1, 32'h20, 0, 0);
    @(negedge clk);
    chk("held_d_resp", d_resp_valid, 1);
    @(posedge clk); #1;
    rst_n = 0; d_resp_ready = 1;
    if_req_valid = 1; if_req_addr = 32'h20; d_req_valid = 1; d_req_addr = 32'h24; d_req_we = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_mid_valid", d_resp_valid, 0);
    for (int i = 0; i < 9; i++) begin
      if (if_req_valid && if_req_ready) begin g_port.push_back(0); g_cyc.push_back(cyc); end
      if (d_req_valid && d_req_ready) begin g_port.push_back(1); g_cyc.push_back(cyc); end
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("cont_count", g_port.size(), 5);
    for (int i = 0; i < 4 && i < g_port.size(); i++) begin
      chk("cont_port", g_port[i], (i % 2 == 0) ? 1 : 0);
      if (i > 0) chk("cont_gap", g_cyc[i] - g_cyc[i-1], 2);
    end
    @(posedge clk); #1;
    if_req_valid = 0; d_req_valid = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ai = if_req_valid && if_req_ready;
      ad = d_req_valid && d_req_ready;
      @(posedge clk); #1;
      rst_n = (n != 1500);
      if (!if_req_valid || ai) begin
        if_req_valid = $urandom_range(0, 2) != 0; if_req_addr = gen_addr();
      end
      if (!d_req_valid || ad) begin
        d_req_valid = $urandom_range(0, 2) != 0; d_req_addr = gen_addr();
        d_req_we = $urandom_range(0, 1) != 0; d_req_wdata = $urandom;
      end
      if_resp_ready = $urandom_range(0, 3) != 0;
      d_resp_ready = $urandom_range(0, 3) != 0;
    end
    rst_n = 1; if_req_valid = 0; d_req_valid = 0; if_resp_ready = 1; d_resp_ready = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drained", q_if.size() + q_d.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
